// File: rtl/wshb_arbiter_rr.sv
// Round-robin Wishbone arbiter: NB_MASTERS masters share one slave, ownership held for a whole s_cyc.
// Optional per-master grant counters on output grant_cnt when WSHB_ARB_STATS_EN is defined.
module wshb_arbiter_rr #(
  parameter int NB_MASTERS = 2,
  parameter int ADR_W      = 32,
  parameter int DAT_W      = 32,
  localparam int SEL_W     = DAT_W / 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NB_MASTERS-1:0]       s_cyc,
  input  logic [NB_MASTERS-1:0]       s_stb,
  input  logic [NB_MASTERS-1:0]       s_we,
  input  logic [NB_MASTERS*ADR_W-1:0] s_adr,
  input  logic [NB_MASTERS*DAT_W-1:0] s_dat_ms,
  input  logic [NB_MASTERS*SEL_W-1:0] s_sel,
  input  logic [NB_MASTERS*3-1:0]     s_cti,
  input  logic [NB_MASTERS*2-1:0]     s_bte,
  output logic [NB_MASTERS-1:0]       s_ack,
  output logic [NB_MASTERS-1:0]       s_err,
  output logic [NB_MASTERS-1:0]       s_rty,
  output logic [NB_MASTERS*DAT_W-1:0] s_dat_sm,
  output logic                        m_cyc,
  output logic                        m_stb,
  output logic                        m_we,
  output logic [ADR_W-1:0]            m_adr,
  output logic [DAT_W-1:0]            m_dat_ms,
  output logic [SEL_W-1:0]            m_sel,
  output logic [2:0]                  m_cti,
  output logic [1:0]                  m_bte,
  input  logic                        m_ack,
  input  logic                        m_err,
  input  logic                        m_rty,
  input  logic [DAT_W-1:0]            m_dat_sm,
  output logic [NB_MASTERS-1:0]       grant,
  output logic                        busy
`ifdef WSHB_ARB_STATS_EN
  ,
  output logic [NB_MASTERS*16-1:0]    grant_cnt
`endif
);

  localparam int IDX_W = $clog2(NB_MASTERS);
  localparam logic [IDX_W:0]   NB_L     = (IDX_W+1)'(NB_MASTERS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_MASTERS - 1);

  typedef enum logic {IDLE, OWN} state_t;

  state_t                 state_q, state_d;
  logic [IDX_W-1:0]       owner_q, owner_d;
  logic [IDX_W-1:0]       ptr_q, ptr_d;
  logic [NB_MASTERS-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]       base, sel_idx;
  logic [IDX_W:0]         cand;
  logic                   sel_found, own_act, owner_cyc, grant_evt;
  logic [NB_MASTERS-1:0]  is_owner;

  logic [ADR_W-1:0] adr_a [NB_MASTERS];
  logic [DAT_W-1:0] dat_a [NB_MASTERS];
  logic [SEL_W-1:0] sel_a [NB_MASTERS];
  logic [2:0]       cti_a [NB_MASTERS];
  logic [1:0]       bte_a [NB_MASTERS];

  genvar gi;
  generate
    for (gi = 0; gi < NB_MASTERS; gi++) begin : g_slice
      assign adr_a[gi] = s_adr[gi*ADR_W +: ADR_W];
      assign dat_a[gi] = s_dat_ms[gi*DAT_W +: DAT_W];
      assign sel_a[gi] = s_sel[gi*SEL_W +: SEL_W];
      assign cti_a[gi] = s_cti[gi*3 +: 3];
      assign bte_a[gi] = s_bte[gi*2 +: 2];
      assign is_owner[gi]            = own_act && (owner_q == IDX_W'(gi));
      assign s_ack[gi]               = is_owner[gi] & m_ack;
      assign s_err[gi]               = is_owner[gi] & m_err;
      assign s_rty[gi]               = is_owner[gi] & m_rty;
      assign s_dat_sm[gi*DAT_W +: DAT_W] = is_owner[gi] ? m_dat_sm : '0;
    end
  endgenerate

  assign own_act   = (state_q == OWN);
  assign owner_cyc = s_cyc[owner_q];

  // Search starts just after the current owner (when releasing) or the last owner (when idle).
  always_comb begin
    base      = own_act ? owner_q : ptr_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NB_MASTERS; k++) begin
      cand = {1'b0, base} + (IDX_W+1)'(k);
      if (cand >= NB_L) cand = cand - NB_L;
      if (!sel_found && s_cyc[cand[IDX_W-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = cand[IDX_W-1:0];
      end
    end
  end

  assign grant_evt = sel_found && (!own_act || !owner_cyc);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    case (state_q)
      IDLE: begin
        if (grant_evt) begin
          state_d          = OWN;
          owner_d          = sel_idx;
          grant_d          = '0;
          grant_d[sel_idx] = 1'b1;
        end
      end
      OWN: begin
        if (!owner_cyc) begin
          ptr_d = owner_q;
          if (grant_evt) begin
            owner_d          = sel_idx;
            grant_d          = '0;
            grant_d[sel_idx] = 1'b1;
          end else begin
            state_d = IDLE;
            grant_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= LAST_IDX;
      grant_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
    end
  end

  // m_cyc drops in the release cycle, guaranteeing a gap between owners.
  assign m_cyc    = own_act & owner_cyc;
  assign m_stb    = own_act & owner_cyc & s_stb[owner_q];
  assign m_we     = s_we[owner_q];
  assign m_adr    = adr_a[owner_q];
  assign m_dat_ms = dat_a[owner_q];
  assign m_sel    = sel_a[owner_q];
  assign m_cti    = cti_a[owner_q];
  assign m_bte    = bte_a[owner_q];
  assign grant    = grant_q;
  assign busy     = own_act;

`ifdef WSHB_ARB_STATS_EN
  generate
    for (gi = 0; gi < NB_MASTERS; gi++) begin : g_cnt
      logic [15:0] cnt_q, cnt_d;
      always_comb begin
        cnt_d = cnt_q;
        if (grant_evt && (sel_idx == IDX_W'(gi)) && (cnt_q != 16'hFFFF))
          cnt_d = cnt_q + 16'd1;
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
      end
      assign grant_cnt[gi*16 +: 16] = cnt_q;
    end
  endgenerate
`endif

endmodule

// File: tb/tb_wshb_arbiter_rr.sv
// Directed bench for wshb_arbiter_rr: a 2-master instance (a_*) and a 3-master instance (b_*).
module tb_wshb_arbiter_rr;

  logic clk, rst_n;
  int tests_run = 0;
  int tests_failed = 0;

  logic [1:0]  a_cyc, a_stb, a_we, a_ack, a_err, a_rty, a_grant;
  logic [63:0] a_adr, a_dat_ms, a_dat_sm;
  logic [7:0]  a_sel;
  logic [5:0]  a_cti;
  logic [3:0]  a_bte, a_m_sel;
  logic        a_m_cyc, a_m_stb, a_m_we, a_m_ack, a_m_err, a_m_rty, a_busy;
  logic [31:0] a_m_adr, a_m_dat_ms, a_m_dat_sm;
  logic [2:0]  a_m_cti;
  logic [1:0]  a_m_bte;
`ifdef WSHB_ARB_STATS_EN
  logic [31:0] a_grant_cnt;
  logic [47:0] b_grant_cnt;
`endif

  logic [2:0]  b_cyc, b_stb, b_we, b_ack, b_err, b_rty, b_grant;
  logic [95:0] b_adr, b_dat_ms, b_dat_sm;
  logic [11:0] b_sel;
  logic [8:0]  b_cti;
  logic [5:0]  b_bte;
  logic        b_m_cyc, b_m_stb, b_m_we, b_m_ack, b_m_err, b_m_rty, b_busy;
  logic [31:0] b_m_adr, b_m_dat_ms, b_m_dat_sm;
  logic [3:0]  b_m_sel;
  logic [2:0]  b_m_cti;
  logic [1:0]  b_m_bte;

  wshb_arbiter_rr #(.NB_MASTERS(2), .ADR_W(32), .DAT_W(32)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(a_cyc), .s_stb(a_stb), .s_we(a_we), .s_adr(a_adr), .s_dat_ms(a_dat_ms),
    .s_sel(a_sel), .s_cti(a_cti), .s_bte(a_bte),
    .s_ack(a_ack), .s_err(a_err), .s_rty(a_rty), .s_dat_sm(a_dat_sm),
    .m_cyc(a_m_cyc), .m_stb(a_m_stb), .m_we(a_m_we), .m_adr(a_m_adr), .m_dat_ms(a_m_dat_ms),
    .m_sel(a_m_sel), .m_cti(a_m_cti), .m_bte(a_m_bte),
    .m_ack(a_m_ack), .m_err(a_m_err), .m_rty(a_m_rty), .m_dat_sm(a_m_dat_sm),
    .grant(a_grant), .busy(a_busy)
`ifdef WSHB_ARB_STATS_EN
    , .grant_cnt(a_grant_cnt)
`endif
  );

  wshb_arbiter_rr #(.NB_MASTERS(3), .ADR_W(32), .DAT_W(32)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .s_cyc(b_cyc), .s_stb(b_stb), .s_we(b_we), .s_adr(b_adr), .s_dat_ms(b_dat_ms),
    .s_sel(b_sel), .s_cti(b_cti), .s_bte(b_bte),
    .s_ack(b_ack), .s_err(b_err), .s_rty(b_rty), .s_dat_sm(b_dat_sm),
    .m_cyc(b_m_cyc), .m_stb(b_m_stb), .m_we(b_m_we), .m_adr(b_m_adr), .m_dat_ms(b_m_dat_ms),
    .m_sel(b_m_sel), .m_cti(b_m_cti), .m_bte(b_m_bte),
    .m_ack(b_m_ack), .m_err(b_m_err), .m_rty(b_m_rty), .m_dat_sm(b_m_dat_sm),
    .grant(b_grant), .busy(b_busy)
`ifdef WSHB_ARB_STATS_EN
    , .grant_cnt(b_grant_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    a_cyc = '0; a_stb = '0; a_we = '0; a_sel = 8'hFF; a_cti = '0; a_bte = '0;
    a_adr = {32'h2000_0000, 32'h1000_0000};
    a_dat_ms = {32'hBBBB_0001, 32'hAAAA_0000};
    a_m_ack = 0; a_m_err = 0; a_m_rty = 0; a_m_dat_sm = '0;
    b_cyc = '0; b_stb = '0; b_we = '0; b_sel = 12'hFFF; b_cti = '0; b_bte = '0;
    b_adr = {32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    b_dat_ms = '0;
    b_m_ack = 0; b_m_err = 0; b_m_rty = 0; b_m_dat_sm = '0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    a_cyc = 2'b11; a_stb = 2'b11; a_m_ack = 1; a_m_dat_sm = 32'hDEADBEEF;
    #12;
    tests_run++;
    if ({a_grant, a_busy, a_m_cyc, a_m_stb} !== 5'b0) begin
      tests_failed++;
      $display("FAIL reset_ctrl: grant=%b busy=%b m_cyc=%b m_stb=%b, expected all 0", a_grant, a_busy, a_m_cyc, a_m_stb);
    end
    tests_run++;
    if (a_ack !== 2'b00 || a_dat_sm !== 64'h0) begin
      tests_failed++;
      $display("FAIL reset_slave_side: s_ack=%b s_dat_sm=%h, expected 0", a_ack, a_dat_sm);
    end
    @(negedge clk);
    rst_n = 1; a_m_ack = 0;
    @(posedge clk); #1;
    tests_run++;
    if (a_grant !== 2'b01 || a_m_cyc !== 1'b1 || a_m_adr !== 32'h1000_0000) begin
      tests_failed++;
      $display("FAIL first_grant: grant=%b m_cyc=%b m_adr=%h, expected 01 1 10000000", a_grant, a_m_cyc, a_m_adr);
    end
    a_cyc = 2'b10; #1;
    tests_run++;
    if (a_m_cyc !== 1'b0 || a_grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL release_gap: m_cyc=%b grant=%b, expected 0 01", a_m_cyc, a_grant);
    end
    @(posedge clk); #1;
    tests_run++;
    if (a_grant !== 2'b10 || a_m_cyc !== 1'b1 || a_m_adr !== 32'h2000_0000) begin
      tests_failed++;
      $display("FAIL handover: grant=%b m_cyc=%b m_adr=%h, expected 10 1 20000000", a_grant, a_m_cyc, a_m_adr);
    end
    $display("[TB] reset/handover scenario done");
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_g [4];
    exp_g[0] = 3'b001; exp_g[1] = 3'b010; exp_g[2] = 3'b100; exp_g[3] = 3'b001;
    apply_reset();
    b_cyc = 3'b111; b_stb = 3'b111;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      tests_run++;
      if (b_grant !== exp_g[i] || b_m_cyc !== 1'b1) begin
        tests_failed++;
        $display("FAIL rr_grant[%0d]: grant=%b m_cyc=%b, expected %b 1", i, b_grant, b_m_cyc, exp_g[i]);
      end
      repeat (3) @(posedge clk);
      #1;
      b_cyc = 3'b111 & ~exp_g[i];
      #1;
      tests_run++;
      if (b_m_cyc !== 1'b0) begin
        tests_failed++;
        $display("FAIL rr_gap[%0d]: m_cyc=%b, expected 0", i, b_m_cyc);
      end
      @(posedge clk); #1;
      b_cyc = 3'b111;
      $display("[TB] rr turn %0d expected grant %b", i, exp_g[i]);
    end
  endtask

  task automatic test_slave_forward();
    apply_reset();
    b_cyc = 3'b010; b_stb = 3'b010; b_we = 3'b010;
    @(posedge clk); #1;
    tests_run++;
    if (b_grant !== 3'b010 || b_m_adr !== 32'h3000_0001 || b_m_we !== 1'b1 || b_m_stb !== 1'b1) begin
      tests_failed++;
      $display("FAIL fwd_owner_mux: grant=%b m_adr=%h m_we=%b m_stb=%b, expected 010 30000001 1 1", b_grant, b_m_adr, b_m_we, b_m_stb);
    end
    b_m_ack = 1; b_m_dat_sm = 32'hDEADBEEF; #1;
    tests_run++;
    if (b_ack !== 3'b010 || b_dat_sm !== {32'h0, 32'hDEADBEEF, 32'h0} || b_err !== 3'b000) begin
      tests_failed++;
      $display("FAIL fwd_ack: s_ack=%b s_err=%b s_dat_sm=%h, expected 010 000 00000000deadbeef00000000", b_ack, b_err, b_dat_sm);
    end
    b_m_ack = 0; b_m_rty = 1; #1;
    tests_run++;
    if (b_rty !== 3'b010 || b_ack !== 3'b000) begin
      tests_failed++;
      $display("FAIL fwd_rty: s_rty=%b s_ack=%b, expected 010 000", b_rty, b_ack);
    end
    b_m_rty = 0; b_stb = 3'b000; #1;
    tests_run++;
    if (b_m_stb !== 1'b0 || b_m_cyc !== 1'b1) begin
      tests_failed++;
      $display("FAIL stb_gate: m_stb=%b m_cyc=%b, expected 0 1", b_m_stb, b_m_cyc);
    end
    $display("[TB] slave forwarding scenario done");
  endtask

  task automatic test_burst_hold();
    logic [2:0] exp_cti;
    apply_reset();
    a_cyc = 2'b01; a_stb = 2'b01; a_cti = {3'b000, 3'b010};
    @(posedge clk); #1;
    a_cyc = 2'b11; a_stb = 2'b11;
    for (int beat = 0; beat < 16; beat++) begin
      exp_cti = (beat == 15) ? 3'b111 : 3'b010;
      a_cti[2:0] = exp_cti;
      #1;
      tests_run++;
      if (a_grant !== 2'b01 || a_m_cyc !== 1'b1 || a_m_cti !== exp_cti) begin
        tests_failed++;
        $display("FAIL burst_hold[%0d]: grant=%b m_cyc=%b m_cti=%b, expected 01 1 %b", beat, a_grant, a_m_cyc, a_m_cti, exp_cti);
      end
      @(posedge clk); #1;
    end
    a_cyc = 2'b10; #1;
    tests_run++;
    if (a_m_cyc !== 1'b0 || a_grant !== 2'b01) begin
      tests_failed++;
      $display("FAIL burst_gap: m_cyc=%b grant=%b, expected 0 01", a_m_cyc, a_grant);
    end
    @(posedge clk); #1;
    tests_run++;
    if (a_grant !== 2'b10 || a_m_cti !== 3'b000) begin
      tests_failed++;
      $display("FAIL burst_next: grant=%b m_cti=%b, expected 10 000", a_grant, a_m_cti);
    end
    $display("[TB] burst hold scenario done");
  endtask

  task automatic test_reset_mid_burst();
    apply_reset();
    a_cyc = 2'b01; a_stb = 2'b01; a_cti = {3'b000, 3'b010};
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (a_grant !== 2'b01 || a_m_cyc !== 1'b1) begin
      tests_failed++;
      $display("FAIL pre_reset_own: grant=%b m_cyc=%b, expected 01 1", a_grant, a_m_cyc);
    end
    @(negedge clk); #2;
    rst_n = 0; a_m_ack = 1;
    #1;
    tests_run++;
    if (a_grant !== 2'b00 || a_m_cyc !== 1'b0 || a_busy !== 1'b0 || a_ack !== 2'b00) begin
      tests_failed++;
      $display("FAIL async_abort: grant=%b m_cyc=%b busy=%b s_ack=%b, expected 00 0 0 00", a_grant, a_m_cyc, a_busy, a_ack);
    end
    a_cyc = 2'b10; a_stb = 2'b10; a_m_ack = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk); #1;
    tests_run++;
    if (a_grant !== 2'b10 || a_m_cyc !== 1'b1) begin
      tests_failed++;
      $display("FAIL post_reset_grant: grant=%b m_cyc=%b, expected 10 1", a_grant, a_m_cyc);
    end
    $display("[TB] reset mid-burst scenario done");
  endtask

`ifdef WSHB_ARB_STATS_EN
  task automatic test_grant_stats();
    apply_reset();
    for (int i = 0; i < 70000; i++) begin
      a_cyc = 2'b01;
      @(posedge clk); #1;
      a_cyc = 2'b00;
      @(posedge clk); #1;
      if (i == 2) begin
        tests_run++;
        if (a_grant_cnt !== {16'd0, 16'd3}) begin
          tests_failed++;
          $display("FAIL stats_early: grant_cnt=%h, expected 00000003", a_grant_cnt);
        end
      end
    end
    tests_run++;
    if (a_grant_cnt !== {16'd0, 16'hFFFF}) begin
      tests_failed++;
      $display("FAIL stats_saturate: grant_cnt=%h, expected 0000ffff", a_grant_cnt);
    end
    $display("[TB] grant stats scenario done");
  endtask
`endif

  initial begin
    clk = 0;
    rst_n = 1;
    idle_inputs();
    #1;
    test_reset();
    test_round_robin();
    test_slave_forward();
    test_burst_hold();
    test_reset_mid_burst();
`ifdef WSHB_ARB_STATS_EN
    test_grant_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
